// File: rtl/serial_seg_scanner_if.sv
// Serial segment stream and display drive bundle for serial_seg_scanner.
// The master side drives the serial lines and brightness; the slave side drives the display.
interface serial_seg_scanner_if;
  logic       i_sclk;
  logic       i_sdat;
  logic       i_slatch;
  logic [3:0] i_bright;
  logic [7:0] o_seg;
  logic [5:0] o_dig;
  logic       o_frame;
  logic       o_err;

  modport master (
    output i_sclk, i_sdat, i_slatch, i_bright,
    input  o_seg, o_dig, o_frame, o_err
  );

  modport slave (
    input  i_sclk, i_sdat, i_slatch, i_bright,
    output o_seg, o_dig, o_frame, o_err
  );
endinterface

// File: rtl/serial_seg_scanner.sv
// Receives six serial segment bytes per frame into a shadow buffer, commits complete frames to a
// display buffer, and scans a 6-digit 7-segment display with brightness PWM.
module serial_seg_scanner #(
  parameter int unsigned DIGIT_CYCLES = 256,
  parameter int unsigned TIMEOUT      = 4096
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  serial_seg_scanner_if.slave  bus
);
  localparam int unsigned SlotW = $clog2(DIGIT_CYCLES);
  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);
  localparam int unsigned Step  = DIGIT_CYCLES / 16;

  // [0],[1] synchroniser, [2] previous synchronised value for edge detection
  logic [2:0] sclk_sync, latch_sync;
  logic [1:0] sdat_sync;
  logic       sclk_rise, latch_rise, sdat_s;

  logic [7:0]       shreg_q, shreg_d;
  logic [3:0]       bits_q, bits_d;
  logic [2:0]       wptr_q, wptr_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic             err_q, err_d;
  logic             frame_q;
  logic             wr_en, commit;
  logic [7:0]       shadow_q [6];
  logic [7:0]       disp_q   [6];

  logic [SlotW-1:0] slot_q;
  logic [2:0]       idx_q;
  logic [7:0]       seg_q;
  logic [5:0]       dig_q;
  logic             lit;

  assign sclk_rise  = sclk_sync[1] & ~sclk_sync[2];
  assign latch_rise = latch_sync[1] & ~latch_sync[2];
  assign sdat_s     = sdat_sync[1];

  // Latch is handled before sclk so a coincident sclk edge starts the next byte.
  always_comb begin
    shreg_d = shreg_q;
    bits_d  = bits_q;
    wptr_d  = wptr_q;
    idle_d  = idle_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    commit  = 1'b0;
    if (latch_rise) begin
      if (bits_q == 4'd8) begin
        wr_en  = 1'b1;
        commit = (wptr_q == 3'd5);
        wptr_d = commit ? 3'd0 : wptr_q + 3'd1;
      end else begin
        err_d  = 1'b1;
        wptr_d = 3'd0;
      end
      bits_d = 4'd0;
    end
    if (sclk_rise) begin
      shreg_d = {shreg_q[6:0], sdat_s};
      if (bits_d != 4'd9) bits_d = bits_d + 4'd1;
    end
    if (sclk_rise || latch_rise) begin
      idle_d = '0;
    end else if (idle_q != IdleW'(TIMEOUT)) begin
      idle_d = idle_q + 1'b1;
    end else begin
      wptr_d = 3'd0;
      bits_d = 4'd0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sclk_sync  <= '0;
      latch_sync <= '0;
      sdat_sync  <= '0;
      shreg_q    <= '0;
      bits_q     <= '0;
      wptr_q     <= '0;
      idle_q     <= '0;
      err_q      <= 1'b0;
      frame_q    <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        shadow_q[i] <= '0;
        disp_q[i]   <= '0;
      end
    end else begin
      sclk_sync  <= {sclk_sync[1:0], bus.i_sclk};
      latch_sync <= {latch_sync[1:0], bus.i_slatch};
      sdat_sync  <= {sdat_sync[0], bus.i_sdat};
      shreg_q    <= shreg_d;
      bits_q     <= bits_d;
      wptr_q     <= wptr_d;
      idle_q     <= idle_d;
      err_q      <= err_d;
      frame_q    <= commit;
      if (wr_en) shadow_q[wptr_q] <= shreg_q;
      if (commit) begin
        for (int i = 0; i < 5; i++) disp_q[i] <= shadow_q[i];
        disp_q[5] <= shreg_q;
      end
    end
  end

  // Slot 0 is always blank to hide digit-switch ghosting.
  always_comb begin
    lit = (slot_q != '0) && (32'(slot_q) < 32'(bus.i_bright) * Step);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      slot_q <= '0;
      idx_q  <= '0;
      seg_q  <= '0;
      dig_q  <= 6'b000001;
    end else begin
      if (slot_q == SlotW'(DIGIT_CYCLES - 1)) begin
        slot_q <= '0;
        idx_q  <= (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
      end else begin
        slot_q <= slot_q + 1'b1;
      end
      seg_q <= lit ? disp_q[idx_q] : 8'h00;
      dig_q <= 6'b000001 << idx_q;
    end
  end

  assign bus.o_seg   = seg_q;
  assign bus.o_dig   = dig_q;
  assign bus.o_frame = frame_q;
  assign bus.o_err   = err_q;
endmodule

// File: tb/tb_serial_seg_scanner.sv
// Directed-plus-random bench for serial_seg_scanner with a byte/frame-level reference model.
module tb_serial_seg_scanner;
  localparam int unsigned DC = 16;
  localparam int unsigned TO = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_seg_scanner_if bus ();

  serial_seg_scanner #(
    .DIGIT_CYCLES(DC),
    .TIMEOUT     (TO)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int         checks = 0;
  int         errors = 0;
  int         frame_cnt = 0;
  int         exp_frames = 0;
  logic       exp_err = 1'b0;
  logic [7:0] exp_disp [6];
  logic [7:0] shq [$];
  logic [7:0] fr [6];
  int         ph = 4;

  always @(negedge clk) if (bus.o_frame === 1'b1) frame_cnt++;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no finish, required finish before 2ms");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: bytes with 8 bits accumulate; the sixth one completes a frame.
  task automatic model_byte(input logic [7:0] b, input int nbits);
    if (nbits == 8) begin
      shq.push_back(b);
      if (shq.size() == 6) begin
        for (int i = 0; i < 6; i++) exp_disp[i] = shq[i];
        shq.delete();
        exp_frames++;
      end
    end else begin
      exp_err = 1'b1;
      shq.delete();
    end
  endtask

  task automatic clock_bit(input logic b);
    bus.i_sdat = b;
    repeat (ph) @(negedge clk);
    bus.i_sclk = 1'b1;
    repeat (ph) @(negedge clk);
    bus.i_sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int nbits);
    for (int j = 0; j < nbits; j++) clock_bit(b[7-j]);
    repeat (ph) @(negedge clk);
    bus.i_slatch = 1'b1;
    repeat (ph) @(negedge clk);
    bus.i_slatch = 1'b0;
    model_byte(b, nbits);
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame();
    for (int i = 0; i < 6; i++) send_byte(fr[i], 8);
  endtask

  // Latch rise coincides with the first sclk rise of the following byte.
  task automatic send_frame_overlap();
    for (int i = 0; i < 6; i++) begin
      for (int j = (i == 0) ? 0 : 1; j < 8; j++) clock_bit(fr[i][7-j]);
      if (i < 5) begin
        bus.i_sdat = fr[i+1][7];
        repeat (ph) @(negedge clk);
        bus.i_sclk   = 1'b1;
        bus.i_slatch = 1'b1;
        repeat (ph) @(negedge clk);
        bus.i_sclk   = 1'b0;
        bus.i_slatch = 1'b0;
        model_byte(fr[i], 8);
      end else begin
        repeat (ph) @(negedge clk);
        bus.i_slatch = 1'b1;
        repeat (ph) @(negedge clk);
        bus.i_slatch = 1'b0;
        model_byte(fr[i], 8);
        repeat (4) @(negedge clk);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    if (n >= int'(TO)) shq.delete();
  endtask

  task automatic wait_dig_change();
    logic [5:0] prev;
    logic       ok;
    prev = bus.o_dig;
    ok   = 1'b0;
    for (int c = 0; c < 64 && !ok; c++) begin
      @(negedge clk);
      if (bus.o_dig !== prev) ok = 1'b1;
    end
    chk("dig_change", 32'(ok), 32'd1);
  endtask

  task automatic read_display();
    logic [5:0] prev, want;
    logic       ok;
    bus.i_bright = 4'd15;
    for (int k = 0; k < 6; k++) begin
      want = 6'd1 << k;
      prev = bus.o_dig;
      ok   = 1'b0;
      for (int c = 0; c < 200 && !ok; c++) begin
        @(negedge clk);
        if (bus.o_dig !== prev && bus.o_dig === want) ok = 1'b1;
        prev = bus.o_dig;
      end
      chk($sformatf("dig%0d_seen", k), 32'(ok), 32'd1);
      repeat (5) @(negedge clk);
      chk($sformatf("seg%0d", k), 32'(bus.o_seg), 32'(exp_disp[k]));
    end
  endtask

  // Needs every displayed byte nonzero so lit cycles are countable.
  task automatic check_bright(input logic [3:0] b);
    logic [5:0] cur;
    int         period, lit;
    bus.i_bright = b;
    wait_dig_change();
    wait_dig_change();
    cur    = bus.o_dig;
    period = 0;
    lit    = 0;
    while (bus.o_dig === cur && period < 64) begin
      if (bus.o_seg !== 8'h00) lit++;
      period++;
      @(negedge clk);
    end
    chk("dig_period", 32'(period), DC);
    chk($sformatf("lit_b%0d", b), 32'(lit), (b == 0) ? 32'd0 : 32'(b) - 32'd1);
    chk("dig_rotate", 32'(bus.o_dig), 32'({cur[4:0], cur[5]}));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_seg"}, 32'(bus.o_seg), 32'h00);
    chk({tag, "_dig"}, 32'(bus.o_dig), 32'h01);
    chk({tag, "_frame"}, 32'(bus.o_frame), 32'd0);
    chk({tag, "_err"}, 32'(bus.o_err), 32'd0);
  endtask

  initial begin
    bus.i_sclk   = 1'b0;
    bus.i_sdat   = 1'b0;
    bus.i_slatch = 1'b0;
    bus.i_bright = 4'd15;
    for (int i = 0; i < 6; i++) exp_disp[i] = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // First known frame
    fr = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D};
    send_frame();
    chk("frame1_cnt", 32'(frame_cnt), 32'(exp_frames));
    chk("frame1_err", 32'(bus.o_err), 32'(exp_err));
    read_display();

    // Brightness / scan timing
    check_bright(4'd15);
    check_bright(4'd0);
    check_bright(4'($urandom_range(1, 14)));
    check_bright(4'($urandom_range(1, 14)));

    // Stale partial frame discarded by idle timeout
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 8);
    idle(TO + 10);
    for (int i = 0; i < 6; i++) fr[i] = 8'($urandom);
    send_frame();
    chk("timeout_cnt", 32'(frame_cnt), 32'(exp_frames));
    chk("timeout_err", 32'(bus.o_err), 32'd0);
    read_display();

    // Random frames at random phase lengths
    for (int n = 0; n < 3; n++) begin
      ph = $urandom_range(3, 6);
      for (int i = 0; i < 6; i++) fr[i] = 8'($urandom);
      send_frame();
      chk("rand_cnt", 32'(frame_cnt), 32'(exp_frames));
      read_display();
    end
    ph = 4;

    // Coincident latch and sclk edges
    for (int i = 0; i < 6; i++) fr[i] = 8'($urandom);
    send_frame_overlap();
    chk("overlap_cnt", 32'(frame_cnt), 32'(exp_frames));
    read_display();

    // Short byte on the third byte of a frame
    send_byte(8'($urandom), 8);
    send_byte(8'($urandom), 8);
    send_byte(8'($urandom), 7);
    chk("short_err", 32'(bus.o_err), 32'(exp_err));
    chk("short_cnt", 32'(frame_cnt), 32'(exp_frames));
    for (int i = 0; i < 6; i++) fr[i] = 8'($urandom);
    send_frame();
    chk("recover_cnt", 32'(frame_cnt), 32'(exp_frames));
    read_display();

    // Asynchronous reset mid-byte, mid-frame
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 8);
    for (int j = 0; j < 4; j++) clock_bit(1'($urandom));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async");
    shq.delete();
    exp_err = 1'b0;
    for (int i = 0; i < 6; i++) exp_disp[i] = 8'h00;
    bus.i_sdat = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    read_display();
    for (int i = 0; i < 6; i++) fr[i] = 8'($urandom);
    send_frame();
    chk("post_rst_cnt", 32'(frame_cnt), 32'(exp_frames));
    chk("post_rst_err", 32'(bus.o_err), 32'd0);
    read_display();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
